llki_mock_tss_keyload: RTL and testbench

LLKI_MOCK_TSS_KEYLOAD -- requirements
Module: llki_mock_tss_keyload

---
 rtl/llki_mock_tss_keyload_if.sv | 30 +++
 rtl/llki_mock_tss_keyload.sv | 160 ++++++++++++++++
 tb/tb_llki_mock_tss_keyload.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llki_mock_tss_keyload_if.sv
// LLKI key-load handshake plus the obfuscated datapath, bundled for the mock TSS.
interface llki_mock_tss_keyload_if #(
    parameter int unsigned NUM_KEY_WORDS = 2
);
    localparam int unsigned KEY_W = 64 * NUM_KEY_WORDS;

    logic [63:0]      llkid_key_data;
    logic             llkid_key_valid;
    logic             llkid_key_ready;
    logic             llkid_key_complete;
    logic             llkid_clear_key;
    logic             llkid_clear_key_ack;
    logic             llkid_key_error;
    logic [KEY_W-1:0] data_in;
    logic             data_in_valid;
    logic [KEY_W-1:0] data_out;
    logic             data_out_valid;

    modport master (
        output llkid_key_data, llkid_key_valid, llkid_clear_key, data_in, data_in_valid,
        input  llkid_key_ready, llkid_key_complete, llkid_clear_key_ack, llkid_key_error,
               data_out, data_out_valid
    );

    modport slave (
        input  llkid_key_data, llkid_key_valid, llkid_clear_key, data_in, data_in_valid,
        output llkid_key_ready, llkid_key_complete, llkid_clear_key_ack, llkid_key_error,
               data_out, data_out_valid
    );
endinterface

// File: rtl/llki_mock_tss_keyload.sv
// Mock TSS: loads a multi-word key with artificial wait states and XORs it over data.
// Define LLKI_MOCKTSS_KEY_LOCK_EN to reject key words once the key is complete.
module llki_mock_tss_keyload #(
    parameter int unsigned                  NUM_KEY_WORDS = 2,
    parameter int unsigned                  WAIT_CYCLES   = 8,
    parameter logic [64*NUM_KEY_WORDS-1:0]  MOCK_KEY      = '0
) (
    input logic                     clk,
    input logic                     rst,
    llki_mock_tss_keyload_if.slave  llki
);
    localparam int unsigned      KEY_W     = 64 * NUM_KEY_WORDS;
    localparam int unsigned      IDX_W     = (NUM_KEY_WORDS > 1) ? $clog2(NUM_KEY_WORDS) : 1;
    localparam int unsigned      CNT_W     = 8;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_KEY_WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_WAIT   = 3'd1,
        WORD_LOADED = 3'd2,
        COMPLETE    = 3'd3,
        CLEAR       = 3'd4,
        CLEAR_WAIT  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             complete_q, complete_d;
    logic             ack_q, ack_d;
    logic [KEY_W-1:0] data_out_q, data_out_d;
    logic             data_out_valid_q, data_out_valid_d;
`ifdef LLKI_MOCKTSS_KEY_LOCK_EN
    logic             error_q, error_d;
`endif

    // Next-state, key/counter updates and registered handshake outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
`ifdef LLKI_MOCKTSS_KEY_LOCK_EN
        error_d = 1'b0;
`endif
        case (state_q)
            IDLE, WORD_LOADED: begin
                if (llki.llkid_clear_key) begin
                    if (state_q == IDLE) ack_d   = 1'b1;
                    else                 state_d = CLEAR;
                end else if (llki.llkid_key_valid) begin
                    key_d[{idx_q, 6'b0} +: 64] = llki.llkid_key_data;
                    cnt_d   = WAIT_INIT;
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                // An expiring wait state wins over a concurrent clear request
                if (cnt_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = COMPLETE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = WORD_LOADED;
                    end
                end else if (llki.llkid_clear_key) begin
                    state_d = CLEAR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            COMPLETE: begin
                if (llki.llkid_clear_key) begin
                    state_d = CLEAR;
                end else if (llki.llkid_key_valid) begin
`ifdef LLKI_MOCKTSS_KEY_LOCK_EN
                    error_d = 1'b1;
`else
                    idx_d      = '0;
                    key_d[63:0] = llki.llkid_key_data;
                    cnt_d      = WAIT_INIT;
                    state_d    = LOAD_WAIT;
`endif
                end
            end
            CLEAR: begin
                key_d   = '0;
                idx_d   = '0;
                cnt_d   = WAIT_INIT;
                state_d = CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                key_d   = '0;
                cnt_d   = WAIT_INIT;
            end
        endcase

        ready_d    = (state_d == IDLE) || (state_d == WORD_LOADED) || (state_d == COMPLETE);
        complete_d = (state_d == COMPLETE);

        // Datapath samples the key as it stands at this edge, partial or not
        data_out_valid_d = llki.data_in_valid;
        data_out_d       = llki.data_in_valid ? (llki.data_in ^ MOCK_KEY ^ key_q) : data_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            key_q            <= '0;
            cnt_q            <= WAIT_INIT;
            ready_q          <= 1'b1;
            complete_q       <= 1'b0;
            ack_q            <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            key_q            <= key_d;
            cnt_q            <= cnt_d;
            ready_q          <= ready_d;
            complete_q       <= complete_d;
            ack_q            <= ack_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

`ifdef LLKI_MOCKTSS_KEY_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= error_d;
    end

    assign llki.llkid_key_error = error_q;
`else
    assign llki.llkid_key_error = 1'b0;
`endif

    assign llki.llkid_key_ready     = ready_q;
    assign llki.llkid_key_complete  = complete_q;
    assign llki.llkid_clear_key_ack = ack_q;
    assign llki.data_out            = data_out_q;
    assign llki.data_out_valid      = data_out_valid_q;
endmodule

// File: tb/tb_llki_mock_tss_keyload.sv
// Scoreboard bench for llki_mock_tss_keyload: a deadline-based key model predicts
// ready/complete per cycle and queues the expected data, ack and error events.
module tb_llki_mock_tss_keyload;
    localparam int unsigned N  = 2;
    localparam int unsigned W  = 3;
    localparam int unsigned KW = 64 * N;
    localparam logic [KW-1:0] MOCK = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    llki_mock_tss_keyload_if #(.NUM_KEY_WORDS(N)) bus ();

    llki_mock_tss_keyload #(
        .NUM_KEY_WORDS(N),
        .WAIT_CYCLES  (W),
        .MOCK_KEY     (MOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .llki(bus)
    );

    typedef struct {
        int            cyc;
        logic [KW-1:0] val;
    } dexp_t;

    dexp_t       dq[$];
    int          ack_q[$];
    int          err_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          done   = 1'b0;

    // Key model: committed word count, pending load/clear deadlines, key words
    logic [63:0] km [N];
    int          loaded;
    bit          load_pend;
    int          load_done;
    int          load_idx;
    bit          clr_pend;
    int          clr_start;
    int          clr_done;

    function automatic logic [KW-1:0] key_vec();
        logic [KW-1:0] kv;
        for (int i = 0; i < int'(N); i++) kv[64*i +: 64] = km[i];
        return kv;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) km[i] = '0;
        loaded    = 0;
        load_pend = 1'b0;
        clr_pend  = 1'b0;
        dq.delete();
        ack_q.delete();
        err_q.delete();
    endtask

    task automatic start_clear(input int s);
        clr_pend  = 1'b1;
        clr_start = s;
        clr_done  = s + int'(W) + 2;
        loaded    = 0;
        load_pend = 1'b0;
    endtask

    task automatic accept(input int s, input int i);
        km[i]     = bus.llkid_key_data;
        load_pend = 1'b1;
        load_idx  = i;
        load_done = s + int'(W) + 1;
    endtask

    // Apply the inputs sampled at edge s to the model
    task automatic model_edge(input int s);
        if (bus.data_in_valid) dq.push_back('{s, bus.data_in ^ MOCK ^ key_vec()});
        if (load_pend) begin
            if (s == load_done) begin
                load_pend = 1'b0;
                loaded    = load_idx + 1;
            end else if (bus.llkid_clear_key) begin
                start_clear(s);
            end
        end else if (clr_pend) begin
            if (s == clr_start + 1) for (int i = 0; i < int'(N); i++) km[i] = '0;
            if (s == clr_done) begin
                clr_pend = 1'b0;
                ack_q.push_back(s);
            end
        end else if (bus.llkid_clear_key) begin
            if (loaded == 0) ack_q.push_back(s);
            else             start_clear(s);
        end else if (bus.llkid_key_valid) begin
            if (loaded == int'(N)) begin
`ifdef LLKI_MOCKTSS_KEY_LOCK_EN
                err_q.push_back(s);
`else
                loaded = 0;
                accept(s, 0);
`endif
            end else begin
                accept(s, loaded);
            end
        end
    endtask

    task automatic tick(input logic v, input logic [63:0] d, input logic c,
                        input logic dv, input logic [KW-1:0] di);
        @(negedge clk);
        bus.llkid_key_valid = v;
        bus.llkid_key_data  = d;
        bus.llkid_clear_key = c;
        bus.data_in_valid   = dv;
        bus.data_in         = di;
        @(posedge clk);
        cyc++;
        model_edge(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 64'h0, 1'b0, 1'b0, '0);
    endtask

    task automatic load(input logic [63:0] d);
        tick(1'b1, d, 1'b0, 1'b0, '0);
        idle(int'(W) + 1);
    endtask

    task automatic probe();
        tick(1'b0, 64'h0, 1'b0, 1'b1, MOCK);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        #2;
        rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle ready/complete/data_out plus queued event matching
    initial begin : monitor
        logic [KW-1:0] hold;
        dexp_t         e;
        hold = '0;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            if (rst) hold = '0;
            chk("ready", KW'(bus.llkid_key_ready), KW'(!(load_pend || clr_pend)));
            chk("complete", KW'(bus.llkid_key_complete),
                KW'(!load_pend && !clr_pend && loaded == int'(N)));
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                e = dq.pop_front();
                chk("data_out_valid_missed", 0, 1);
            end
            if (bus.data_out_valid) begin
                if (dq.size() > 0 && dq[0].cyc == cyc) begin
                    e    = dq.pop_front();
                    hold = e.val;
                    chk("data_out_valid", 1, 1);
                end else begin
                    chk("data_out_valid_unexpected", 1, 0);
                end
            end
            chk("data_out", bus.data_out, hold);
            while (ack_q.size() > 0 && ack_q[0] < cyc) begin
                void'(ack_q.pop_front());
                chk("ack_missed", 0, 1);
            end
            if (bus.llkid_clear_key_ack) begin
                if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                    void'(ack_q.pop_front());
                    chk("ack", 1, 1);
                end else begin
                    chk("ack_unexpected", 1, 0);
                end
            end
            while (err_q.size() > 0 && err_q[0] < cyc) begin
                void'(err_q.pop_front());
                chk("error_missed", 0, 1);
            end
            if (bus.llkid_key_error) begin
                if (err_q.size() > 0 && err_q[0] == cyc) begin
                    void'(err_q.pop_front());
                    chk("error", 1, 1);
                end else begin
                    chk("error_unexpected", 1, 0);
                end
            end
        end
        chk("data_q_drained", KW'(dq.size()), 0);
        chk("ack_q_drained", KW'(ack_q.size()), 0);
        chk("err_q_drained", KW'(err_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        logic [KW-1:0] rd;
        bus.llkid_key_valid = 1'b0;
        bus.llkid_key_data  = '0;
        bus.llkid_clear_key = 1'b0;
        bus.data_in_valid   = 1'b0;
        bus.data_in         = '0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        rst = 1'b0;
        idle(2);

        // Two-word load, then read the key back through the datapath
        load(64'h1111);
        load(64'h2222);
        probe();
        idle(1);

        // Clear from COMPLETE, then clear in IDLE
        tick(1'b0, 64'h0, 1'b1, 1'b0, '0);
        idle(int'(W) + 3);
        tick(1'b0, 64'h0, 1'b1, 1'b0, '0);
        idle(2);

        // Clear while the wait counter reads 2, with a partial-key probe first
        tick(1'b1, 64'h3333, 1'b0, 1'b1, MOCK);
        tick(1'b0, 64'h0, 1'b0, 1'b1, MOCK);
        tick(1'b0, 64'h0, 1'b1, 1'b0, '0);
        idle(int'(W) + 3);
        probe();

        // Clear arriving exactly when the wait expires is ignored
        tick(1'b1, 64'h4444, 1'b0, 1'b0, '0);
        idle(int'(W));
        tick(1'b0, 64'h0, 1'b1, 1'b0, '0);
        idle(2);
        load(64'h5555);
        probe();

        // Word offered while complete
        tick(1'b1, 64'haaaa, 1'b0, 1'b0, '0);
        idle(int'(W) + 1);
        probe();

        // Reset during the second word's wait, then reload from index 0
        tick(1'b0, 64'h0, 1'b1, 1'b0, '0);
        idle(int'(W) + 3);
        load(64'h6666);
        tick(1'b1, 64'h7777, 1'b0, 1'b0, '0);
        idle(1);
        pulse_reset();
        load(64'h8888);
        probe();

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            for (int j = 0; j < int'(KW / 32); j++) rd[32*j +: 32] = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
            end else begin
                tick(1'($urandom_range(0, 1)), {$urandom, $urandom},
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rd);
            end
        end
        idle(int'(W) + 4);
        done = 1'b1;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end
endmodule
